// File: rtl/shift_or_pkg.sv
// Shared constants and mode decoding for the shift-OR pipeline.
package shift_or_pkg;

  localparam int unsigned MODE_SHL = 0;
  localparam int unsigned MODE_SHR = 1;
  localparam int unsigned MODE_ROL = 2;
  localparam int unsigned CNT_W    = 16;

  typedef enum logic [1:0] {
    OP_SHL,
    OP_SHR,
    OP_ROL
  } op_e;

  // Unknown mode values fall back to shift left.
  function automatic op_e decode_mode(int unsigned mode);
    case (mode)
      MODE_SHR: return OP_SHR;
      MODE_ROL: return OP_ROL;
      default:  return OP_SHL;
    endcase
  endfunction

endpackage

// File: rtl/shift_or_stage.sv
// Combinational stage: y = x | op(x), op a constant shift or rotate.
module shift_or_stage
  import shift_or_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned SHIFT = 1,
  parameter int unsigned MODE  = 0
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  localparam op_e         OP  = decode_mode(MODE);
  localparam int unsigned ROT = SHIFT % WIDTH;

  logic [WIDTH-1:0] op;

  // Shifts of WIDTH or more contribute nothing; rotation by 0 is identity.
  always_comb begin
    op = '0;
    case (OP)
      OP_SHR:  op = (SHIFT >= WIDTH) ? '0 : (x >> SHIFT);
      OP_ROL:  op = (x << ROT) | (x >> (WIDTH - ROT));
      default: op = (SHIFT >= WIDTH) ? '0 : (x << SHIFT);
    endcase
    y = x | op;
  end

endmodule

// File: rtl/shift_or_pipe.sv
// Stalling shift-OR pipeline with a sticky first-nonzero-output detector.
module shift_or_pipe
  import shift_or_pkg::*;
#(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned SHIFT  = 1,
  parameter int unsigned STAGES = 2,
  parameter int unsigned MODE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              hit,
  output logic [CNT_W-1:0]  hit_count
);

  logic [WIDTH-1:0]  data_q   [STAGES];
  logic [WIDTH-1:0]  data_d   [STAGES];
  logic [WIDTH-1:0]  stage_in [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic              advance;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stage_in[i] = in_data;
      assign vld_d[i]    = in_valid;
    end else begin : g_body
      assign stage_in[i] = data_q[i-1];
      assign vld_d[i]    = vld_q[i-1];
    end

    shift_or_stage #(
      .WIDTH (WIDTH),
      .SHIFT (SHIFT),
      .MODE  (MODE)
    ) u_stage (
      .x (stage_in[i]),
      .y (data_d[i])
    );
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign advance   = !out_valid || out_ready;
  // Reset empties the pipe, so accepting during reset is harmless.
  assign in_ready  = advance || rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else if (advance) begin
      vld_q <= vld_d;
      for (int unsigned i = 0; i < STAGES; i++) data_q[i] <= data_d[i];
    end
  end

  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic             hit_q, hit_d;
  logic             xfer;

  assign xfer = out_valid && out_ready;

  always_comb begin
    cyc_d       = cyc_q;
    hit_d       = hit_q;
    hit_count_d = hit_count_q;
    if (!hit_q && (cyc_q != '1)) cyc_d = cyc_q + 1'b1;
    if (!hit_q && xfer && (out_data != '0)) begin
      hit_d       = 1'b1;
      hit_count_d = cyc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q       <= '0;
      hit_q       <= 1'b0;
      hit_count_q <= '0;
    end else begin
      cyc_q       <= cyc_d;
      hit_q       <= hit_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign hit       = hit_q;
  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_shift_or_pipe.sv
// Bench for shift_or_pipe: main 8-bit/3-stage instance plus mode variants.
module tb_shift_or_pipe;

  typedef struct {
    logic        v;
    logic [31:0] d;
  } ent_t;

  localparam int unsigned A_SH [3] = '{1, 4, 9};
  localparam int unsigned A_MD [3] = '{1, 2, 0};
  localparam int unsigned A_ST [3] = '{3, 1, 3};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, hit;
  logic [7:0]  out_data;
  logic [15:0] hit_count;

  logic        aux_ready = 1'b1;
  logic        a_ir  [3];
  logic        a_ov  [3];
  logic [7:0]  a_od  [3];
  logic        a_hit [3];
  logic [15:0] a_hc  [3];

  logic        w2_valid = 1'b1;
  logic        w2_ready = 1'b1;
  logic [1:0]  w2_in = 2'b01;
  logic        w2_ir, w2_ov, w2_hit;
  logic [1:0]  w2_od;
  logic [15:0] w2_hc;

  always #5 clk = ~clk;

  shift_or_pipe #(.WIDTH(8), .SHIFT(1), .STAGES(3), .MODE(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .hit(hit), .hit_count(hit_count));

  for (genvar k = 0; k < 3; k++) begin : g_aux
    shift_or_pipe #(.WIDTH(8), .SHIFT(A_SH[k]), .STAGES(A_ST[k]), .MODE(A_MD[k])) u_aux (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ir[k]),
      .in_data(in_data), .out_valid(a_ov[k]), .out_ready(aux_ready),
      .out_data(a_od[k]), .hit(a_hit[k]), .hit_count(a_hc[k]));
  end

  shift_or_pipe #(.WIDTH(2), .SHIFT(1), .STAGES(1), .MODE(0)) w2 (
    .clk(clk), .rst(rst), .in_valid(w2_valid), .in_ready(w2_ir),
    .in_data(w2_in), .out_valid(w2_ov), .out_ready(w2_ready),
    .out_data(w2_od), .hit(w2_hit), .hit_count(w2_hc));

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  ent_t        mq[$];
  ent_t        hq[$];
  logic        m_hit;
  logic [15:0] m_hc, m_cyc;
  logic        last_acc;

  function automatic logic [31:0] fstep(logic [31:0] v, int unsigned w,
                                        int unsigned sh, int unsigned mode);
    logic [31:0] m, op;
    int unsigned r;
    m = (32'd1 << w) - 32'd1;
    v = v & m;
    if (mode == 1) op = (sh >= w) ? 32'd0 : (v >> sh);
    else if (mode == 2) begin
      r  = sh % w;
      op = ((v << r) | (v >> (w - r))) & m;
    end else op = (sh >= w) ? 32'd0 : ((v << sh) & m);
    return (v | op) & m;
  endfunction

  function automatic logic [31:0] fapply(logic [31:0] v, int unsigned w, int unsigned sh,
                                         int unsigned mode, int unsigned n);
    logic [31:0] r;
    r = v;
    for (int unsigned i = 0; i < n; i++) r = fstep(r, w, sh, mode);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    hq.delete();
    for (int unsigned i = 0; i < 3; i++) mq.push_back('{1'b0, 32'd0});
    m_hit = 1'b0;
    m_hc  = '0;
    m_cyc = '0;
  endtask

  // Compare all outputs with the model, then step the model across one edge.
  task automatic tick();
    logic        ev, adv, old_hit;
    logic [31:0] ed, av, ad;
    int unsigned n;
    #2;
    ev  = mq[0].v;
    ed  = mq[0].d;
    adv = !ev || out_ready;
    chk("out_valid", out_valid, ev);
    chk("out_data", out_data, ed);
    chk("in_ready", in_ready, adv || rst);
    chk("hit", hit, m_hit);
    chk("hit_count", hit_count, m_hc);
    n = hq.size();
    for (int unsigned k = 0; k < 3; k++) begin
      av = 0;
      ad = 0;
      if (n >= A_ST[k]) begin
        av = hq[n - A_ST[k]].v;
        ad = fapply(hq[n - A_ST[k]].d, 8, A_SH[k], A_MD[k], A_ST[k]);
      end
      chk($sformatf("aux%0d_valid", k), a_ov[k], av);
      chk($sformatf("aux%0d_data", k), a_od[k], ad);
      chk($sformatf("aux%0d_in_ready", k), a_ir[k], 1'b1);
    end
    last_acc = in_valid && (adv || rst);
    if (rst) model_reset();
    else begin
      old_hit = m_hit;
      if (!old_hit && ev && out_ready && (ed != 0)) begin
        m_hit = 1'b1;
        m_hc  = m_cyc;
      end
      if (!old_hit && m_cyc != 16'hFFFF) m_cyc = m_cyc + 16'd1;
      if (adv) begin
        void'(mq.pop_front());
        mq.push_back('{in_valid, fapply({24'd0, in_data}, 8, 1, 0, 3)});
      end
      hq.push_back('{in_valid, {24'd0, in_data}});
      if (hq.size() > 8) void'(hq.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Initial reset, then model starts from the reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_hit", hit, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Zero stream then nonzero; the 2-bit instance runs alongside.
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h00;
    out_ready = 1'b1;
    chk("w2_valid_c0", w2_ov, 1'b0);
    tick();
    chk("w2_valid_c1", w2_ov, 1'b1);
    chk("w2_data_c1", w2_od, 2'b11);
    chk("w2_hit_c1", w2_hit, 1'b0);
    tick();
    chk("w2_hit_c2", w2_hit, 1'b1);
    chk("w2_hit_count_c2", w2_hc, 16'd1);
    repeat (8) tick();
    in_data = 8'h01;
    tick();
    in_data = 8'h02;
    tick();
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (6) tick();
    chk("zero_then_one_hit", hit, 1'b1);
    chk("zero_then_one_hit_count", hit_count, 16'd13);

    // Single-word latency.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h01;
    tick();
    in_valid = 1'b0;
    in_data = 8'h00;
    chk("lat_c1_valid", out_valid, 1'b0);
    tick();
    chk("lat_c2_valid", out_valid, 1'b0);
    tick();
    chk("lat_c3_valid", out_valid, 1'b1);
    chk("lat_c3_data", out_data, 8'h0F);
    tick();

    // Back-to-back words.
    in_valid = 1'b1;
    in_data = 8'h01;
    tick();
    in_data = 8'h10;
    tick();
    in_data = 8'h00;
    tick();
    in_valid = 1'b0;
    chk("b2b_0", out_data, 8'h0F);
    tick();
    chk("b2b_1", out_data, 8'hF0);
    tick();
    chk("b2b_2_valid", out_valid, 1'b1);
    chk("b2b_2", out_data, 8'h00);
    tick();

    // Backpressure with a full pipe and a held fourth word.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h03;
    tick();
    in_data = 8'h04;
    tick();
    in_data = 8'h05;
    tick();
    in_data = 8'h06;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_hold_data", out_data, 8'h1F);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("drain_1", out_data, 8'h3C);
    tick();
    chk("drain_2", out_data, 8'h3F);
    tick();
    chk("drain_3", out_data, 8'h3E);
    tick();
    chk("drain_empty", out_valid, 1'b0);

    // Settled values through the mode variants.
    in_valid = 1'b1;
    in_data = 8'h80;
    repeat (4) tick();
    chk("shr_80", a_od[0], 8'hF0);
    in_data = 8'h81;
    repeat (4) tick();
    chk("rol4_81", a_od[1], 8'h99);
    in_data = 8'h5A;
    repeat (4) tick();
    chk("shl9_5a", a_od[2], 8'h5A);

    // Randomized traffic with a source that holds until accepted.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    last_acc = 1'b1;
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom % 4) != 0;
      if (!in_valid || last_acc) begin
        in_valid = ($urandom % 3) != 0;
        in_data  = (($urandom % 3) == 0) ? 8'($urandom) : 8'h00;
      end
      tick();
    end

    // Reset with two words in flight and the consumer stalled.
    out_ready = 1'b1;
    in_valid = 1'b0;
    repeat (4) tick();
    in_valid = 1'b1;
    in_data = 8'h11;
    tick();
    in_data = 8'h22;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_hit", hit, 1'b0);
    chk("midrst_hit_count", hit_count, 16'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("midrst_no_ghost", out_valid, 1'b0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
